uriscv_tcm_mem: RTL and testbench
=================================

// Module: uriscv_tcm_mem
// PURPOSE
// - Dual-port 64 KB tightly-coupled memory for the uriscv core: port I fetches instructions, port D loads/stores.
// - Single-cycle, always-accepting, no wait states; byte-addressed, little-endian, 32-bit words.
// - Sits directly on the core's mem_i_*/mem_d_* buses; cache-maintenance inputs are accepted and acknowledged as no-ops.
// PARAMETERS
// - MEM_ADDR_W  16  byte-address width; size = 2**MEM_ADDR_W bytes (16384 x 32-bit words at default)
// PORTS
// - clk_i               in   1   clock; all logic on rising edge
// - rst_i               in   1   reset, asynchronous, active-low
// - mem_i_rd_i          in   1   instruction fetch request
// - mem_i_flush_i       in   1   fetch flush (no-op)
// - mem_i_invalidate_i  in   1   fetch invalidate (no-op)
// - mem_i_pc_i          in   32  fetch byte address (bits [1:0] ignored)
// - mem_d_addr_i        in   32  data byte address (bits [1:0] ignored)
// - mem_d_data_wr_i     in   32  store data
// - mem_d_rd_i          in   1   load request
// - mem_d_wr_i          in   4   store byte enables; bit n -> bits [8n+7:8n]
// - mem_d_cacheable_i   in   1   ignored
// - mem_d_req_tag_i     in   11  request tag, echoed on response
// - mem_d_invalidate_i  in   1   invalidate request (no-op, acked)
// - mem_d_writeback_i   in   1   writeback request (no-op, acked)
// - mem_d_flush_i       in   1   flush request (no-op, acked)
// - mem_i_accept_o      out  1   fetch accepted; constant 1
// - mem_i_valid_o       out  1   mem_i_inst_o valid
// - mem_i_error_o       out  1   fetch error
// - mem_i_inst_o        out  32  fetched word
// - mem_d_data_rd_o     out  32  load data
// - mem_d_accept_o      out  1   data request accepted; constant 1
// - mem_d_ack_o         out  1   data response
// - mem_d_error_o       out  1   data error
// - mem_d_resp_tag_o    out  11  tag of acknowledged request
// BEHAVIOUR
// - Word index = addr[MEM_ADDR_W-1:2]; upper address bits ignored (0x80000000 aliases to offset 0).
// - Port I: mem_i_rd_i at edge N -> mem_i_valid_o=1 and mem_i_inst_o=word during cycle N+1; valid=0 when no request.
// - Port D: request = rd | |wr | flush | invalidate | writeback. Request at edge N -> mem_d_ack_o=1 during N+1,
//   mem_d_resp_tag_o = tag sampled at N; mem_d_data_rd_o = word read at N (pre-write value on store).
// - Stores write only enabled bytes at edge N; other bytes unchanged.
// - Back-to-back requests every cycle supported; one response per request, in order.
// - I read of a word D writes in the same cycle returns old contents; written data visible from next cycle.
// - rd and wr together: write performed, read data is pre-write value, single ack.
// - Reset (rst_i=0, async): valid, ack, error, inst, data_rd, resp_tag -> 0; accept stays 1; memory not cleared.
// - Request in reset-release cycle treated normally. Reset mid-operation discards the pending response.
// - mem_*_error_o = 0 unless CONFIGURATION enables range checking.
// - Simulation task write(input [31:0] addr, input [7:0] data): backdoor byte write to addr[MEM_ADDR_W-1:0], zero time.
// CONFIGURATION
// - TCM_MEM_RANGE_CHECK_EN defined:
//   - Any access with addr[31:MEM_ADDR_W] != 0x8000>>(MEM_ADDR_W-16) still responds on normal timing, but with:
//     - error_o=1 and read data 0
//     - stores suppressed
// - Undefined: no check, address aliasing as above; error outputs tied 0.
// TESTING
// - Backdoor write bytes 13,00,00,00 at 0..3, fetch pc=0x80000000 -> next cycle valid=1, inst=0x00000013.
// - Store addr 0x80000100 data 0xDEADBEEF wr=4'hF, then wr=4'b0010 data 0x0000AB00 -> load 0x80000100 returns 0xDEADABEF.
// - Load tag 0x155 then tag 0x2AA on consecutive cycles -> ack=1 both following cycles, resp_tag 0x155 then 0x2AA.
// - Same cycle: fetch 0x80000200 and store 0x11223344 there -> inst = old word; next fetch returns 0x11223344.
// - mem_d_flush_i=1 alone -> ack=1 next cycle, memory unchanged; assert rst_i=0 mid-stream -> valid/ack drop at once.
// - With TCM_MEM_RANGE_CHECK_EN: load 0x00000000 -> ack=1, error=1, data 0; store there leaves offset 0 unchanged.

Source files
------------

// File: rtl/uriscv_tcm_mem.sv
// uriscv_tcm_mem: dual-port single-cycle tightly-coupled memory for the uriscv core (I fetch + D load/store).
// Optional build macro TCM_MEM_RANGE_CHECK_EN turns out-of-window accesses into error responses.
module uriscv_tcm_mem #(
   parameter int MEM_ADDR_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_i_rd_i,
   input  logic        mem_i_flush_i,
   input  logic        mem_i_invalidate_i,
   input  logic [31:0] mem_i_pc_i,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic        mem_d_cacheable_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   input  logic        mem_d_flush_i,
   output logic        mem_i_accept_o,
   output logic        mem_i_valid_o,
   output logic        mem_i_error_o,
   output logic [31:0] mem_i_inst_o,
   output logic [31:0] mem_d_data_rd_o,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [10:0] mem_d_resp_tag_o
);

   localparam int IDX_W = MEM_ADDR_W - 2;
   localparam int WORDS = 2 ** IDX_W;

   logic [31:0]      ram [0:WORDS-1];
   logic [IDX_W-1:0] i_idx;
   logic [IDX_W-1:0] d_idx;
   logic             d_req;
   logic             i_err;
   logic             d_err;
   logic [3:0]       d_we;

   logic             i_valid_q;
   logic             i_error_q;
   logic [31:0]      i_inst_q;
   logic             d_ack_q;
   logic             d_error_q;
   logic [31:0]      d_data_q;
   logic [10:0]      d_tag_q;

   assign i_idx = mem_i_pc_i[MEM_ADDR_W-1:2];
   assign d_idx = mem_d_addr_i[MEM_ADDR_W-1:2];
   assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;

`ifdef TCM_MEM_RANGE_CHECK_EN
   // The TCM window sits at 0x80000000; anything outside it answers with an error.
   localparam logic [31:0] REGION = 32'h0000_8000 >> (MEM_ADDR_W - 16);
   assign i_err = (mem_i_pc_i[31:MEM_ADDR_W]   != REGION[31-MEM_ADDR_W:0]);
   assign d_err = (mem_d_addr_i[31:MEM_ADDR_W] != REGION[31-MEM_ADDR_W:0]);
`else
   assign i_err = 1'b0;
   assign d_err = 1'b0;
`endif

   assign d_we = d_err ? 4'b0000 : mem_d_wr_i;

   // NOTE: the RAM array has no reset; clearing 16K words would cost a reset sequencer and the core never relies on it.
   always @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (d_we[b]) ram[d_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
      end
   end

   // NOTE: non-blocking RAM updates mean both read ports below see the pre-write word on a same-cycle store.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         i_valid_q <= 1'b0;
         i_error_q <= 1'b0;
         i_inst_q  <= '0;
         d_ack_q   <= 1'b0;
         d_error_q <= 1'b0;
         d_data_q  <= '0;
         d_tag_q   <= '0;
      end else begin
         i_valid_q <= mem_i_rd_i;
         i_error_q <= mem_i_rd_i & i_err;
         if (mem_i_rd_i) i_inst_q <= i_err ? 32'h0 : ram[i_idx];
         d_ack_q   <= d_req;
         d_error_q <= d_req & d_err;
         if (d_req) begin
            d_data_q <= d_err ? 32'h0 : ram[d_idx];
            d_tag_q  <= mem_d_req_tag_i;
         end
      end
   end

   assign mem_i_accept_o   = 1'b1;
   assign mem_i_valid_o    = i_valid_q;
   assign mem_i_error_o    = i_error_q;
   assign mem_i_inst_o     = i_inst_q;
   assign mem_d_accept_o   = 1'b1;
   assign mem_d_ack_o      = d_ack_q;
   assign mem_d_error_o    = d_error_q;
   assign mem_d_data_rd_o  = d_data_q;
   assign mem_d_resp_tag_o = d_tag_q;

   // Cache maintenance on the fetch side and the cacheable hint have no meaning for a TCM.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                            mem_i_pc_i[31:MEM_ADDR_W], mem_i_pc_i[1:0],
                            mem_d_addr_i[31:MEM_ADDR_W], mem_d_addr_i[1:0]};

   // Simulation backdoor: zero-time byte load used by loaders and benches.
   task write(input logic [31:0] addr, input logic [7:0] data);
      ram[addr[MEM_ADDR_W-1:2]][8*addr[1:0] +: 8] = data;
   endtask

endmodule

// File: tb/tb_uriscv_tcm_mem.sv
// Self-checking bench for uriscv_tcm_mem: a word model plus per-port expectation queues.
// Build with TCM_MEM_RANGE_CHECK_EN defined to exercise the range-checked variant.
module tb_uriscv_tcm_mem;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } i_exp_t;

   typedef struct packed {
      logic [31:0] data;
      logic [10:0] tag;
      logic        err;
      logic        chk;
   } d_exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
   logic [31:0] mem_i_pc_i;
   logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
   logic        mem_d_rd_i;
   logic [3:0]  mem_d_wr_i;
   logic        mem_d_cacheable_i;
   logic [10:0] mem_d_req_tag_i;
   logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
   logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
   logic [31:0] mem_i_inst_o, mem_d_data_rd_o;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [10:0] mem_d_resp_tag_o;

   logic [31:0] model [0:16383];
   i_exp_t      i_q [$];
   d_exp_t      d_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   uriscv_tcm_mem dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .mem_i_rd_i         (mem_i_rd_i),
      .mem_i_flush_i      (mem_i_flush_i),
      .mem_i_invalidate_i (mem_i_invalidate_i),
      .mem_i_pc_i         (mem_i_pc_i),
      .mem_d_addr_i       (mem_d_addr_i),
      .mem_d_data_wr_i    (mem_d_data_wr_i),
      .mem_d_rd_i         (mem_d_rd_i),
      .mem_d_wr_i         (mem_d_wr_i),
      .mem_d_cacheable_i  (mem_d_cacheable_i),
      .mem_d_req_tag_i    (mem_d_req_tag_i),
      .mem_d_invalidate_i (mem_d_invalidate_i),
      .mem_d_writeback_i  (mem_d_writeback_i),
      .mem_d_flush_i      (mem_d_flush_i),
      .mem_i_accept_o     (mem_i_accept_o),
      .mem_i_valid_o      (mem_i_valid_o),
      .mem_i_error_o      (mem_i_error_o),
      .mem_i_inst_o       (mem_i_inst_o),
      .mem_d_data_rd_o    (mem_d_data_rd_o),
      .mem_d_accept_o     (mem_d_accept_o),
      .mem_d_ack_o        (mem_d_ack_o),
      .mem_d_error_o      (mem_d_error_o),
      .mem_d_resp_tag_o   (mem_d_resp_tag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
`ifdef TCM_MEM_RANGE_CHECK_EN
      return a[31:16] == 16'h8000;
`else
      return 1'b1;
`endif
   endfunction

   task automatic bd_byte(input logic [31:0] addr, input logic [7:0] data);
      dut.write(addr, data);
      model[addr[15:2]][8*addr[1:0] +: 8] = data;
   endtask

   // Drive one cycle of stimulus (no wait) and queue the responses it must produce.
   task automatic apply(input logic i_rd, input logic [31:0] pc, input logic d_rd, input logic [3:0] d_wr,
                        input logic [31:0] d_addr, input logic [31:0] d_wdata, input logic [10:0] tag,
                        input logic [2:0] maint);
      i_exp_t ie;
      d_exp_t de;
      bit     ok;
      mem_i_rd_i         = i_rd;
      mem_i_pc_i         = pc;
      mem_d_rd_i         = d_rd;
      mem_d_wr_i         = d_wr;
      mem_d_addr_i       = d_addr;
      mem_d_data_wr_i    = d_wdata;
      mem_d_req_tag_i    = tag;
      mem_d_flush_i      = maint[2];
      mem_d_invalidate_i = maint[1];
      mem_d_writeback_i  = maint[0];
      mem_d_cacheable_i  = $urandom_range(0, 1) == 1;
      mem_i_flush_i      = 1'b0;
      mem_i_invalidate_i = 1'b0;
      if (i_rd) begin
         ok      = in_range(pc);
         ie.data = ok ? model[pc[15:2]] : 32'h0;
         ie.err  = !ok;
         i_q.push_back(ie);
      end
      if (d_rd || (|d_wr) || (|maint)) begin
         ok      = in_range(d_addr);
         de.data = ok ? model[d_addr[15:2]] : 32'h0;
         de.tag  = tag;
         de.err  = !ok;
         de.chk  = d_rd || (|d_wr);
         d_q.push_back(de);
         if (ok) begin
            for (int b = 0; b < 4; b++)
               if (d_wr[b]) model[d_addr[15:2]][8*b +: 8] = d_wdata[8*b +: 8];
         end
      end
   endtask

   task automatic drive(input logic i_rd, input logic [31:0] pc, input logic d_rd, input logic [3:0] d_wr,
                        input logic [31:0] d_addr, input logic [31:0] d_wdata, input logic [10:0] tag,
                        input logic [2:0] maint);
      @(negedge clk_i);
      #1;
      apply(i_rd, pc, d_rd, d_wr, d_addr, d_wdata, tag, maint);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
   endtask

   // Every falling edge out of reset: a response is due exactly when one was queued last cycle.
   always @(negedge clk_i) begin
      i_exp_t ie;
      d_exp_t de;
      if (rst_i) begin
         check("i_accept", {31'h0, mem_i_accept_o}, 32'h1);
         check("i_valid", {31'h0, mem_i_valid_o}, {31'h0, i_q.size() != 0});
         if (i_q.size() != 0) begin
            ie = i_q.pop_front();
            if (mem_i_valid_o) begin
               check("i_inst", mem_i_inst_o, ie.data);
               check("i_err", {31'h0, mem_i_error_o}, {31'h0, ie.err});
            end
         end
         check("d_accept", {31'h0, mem_d_accept_o}, 32'h1);
         check("d_ack", {31'h0, mem_d_ack_o}, {31'h0, d_q.size() != 0});
         if (d_q.size() != 0) begin
            de = d_q.pop_front();
            if (mem_d_ack_o) begin
               check("d_tag", {21'h0, mem_d_resp_tag_o}, {21'h0, de.tag});
               check("d_err", {31'h0, mem_d_error_o}, {31'h0, de.err});
               if (de.chk) check("d_data", mem_d_data_rd_o, de.data);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      rst_i = 1'b0;
      apply(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
      repeat (2) @(negedge clk_i);
      check("rst_i_valid", {31'h0, mem_i_valid_o}, 32'h0);
      check("rst_i_err", {31'h0, mem_i_error_o}, 32'h0);
      check("rst_i_inst", mem_i_inst_o, 32'h0);
      check("rst_i_accept", {31'h0, mem_i_accept_o}, 32'h1);
      check("rst_d_ack", {31'h0, mem_d_ack_o}, 32'h0);
      check("rst_d_err", {31'h0, mem_d_error_o}, 32'h0);
      check("rst_d_data", mem_d_data_rd_o, 32'h0);
      check("rst_d_tag", {21'h0, mem_d_resp_tag_o}, 32'h0);
      check("rst_d_accept", {31'h0, mem_d_accept_o}, 32'h1);

      for (int i = 0; i < 65536; i++) bd_byte(32'(i), 8'h00);
      bd_byte(32'h0, 8'h13);
      bd_byte(32'h1, 8'h00);
      bd_byte(32'h2, 8'h00);
      bd_byte(32'h3, 8'h00);
      bd_byte(32'h204, 8'h5A);

      // Release reset with a fetch already on the bus.
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      apply(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);

      drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF, 11'h001, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 4'b0010, 32'h8000_0100, 32'h0000_AB00, 11'h002, 3'b000);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h003, 3'b000);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h155, 3'b000);
      drive(1'b1, 32'h8000_0204, 1'b1, 4'h0, 32'h8000_0003, 32'h0, 11'h2AA, 3'b000);
      idle();

      // Fetch and store to the same word in one cycle.
      drive(1'b1, 32'h8000_0200, 1'b0, 4'hF, 32'h8000_0200, 32'h1122_3344, 11'h004, 3'b000);
      drive(1'b1, 32'h8000_0200, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);

      // Maintenance requests are acknowledged and leave memory intact.
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0100, 32'hFFFF_FFFF, 11'h007, 3'b100);
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0100, 32'hFFFF_FFFF, 11'h008, 3'b010);
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0100, 32'hFFFF_FFFF, 11'h009, 3'b001);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h00A, 3'b000);

      // Load and store together: pre-write data, one ack.
      drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h8000_0104, 32'hCAFE_F00D, 11'h00B, 3'b000);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0104, 32'h0, 11'h00C, 3'b000);
      idle();

      // Accesses outside the 0x8000xxxx window: alias or error depending on the build.
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0000, 32'h0, 11'h010, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, 11'h011, 3'b000);
      drive(1'b1, 32'h0000_0000, 1'b1, 4'h0, 32'h8000_0000, 32'h0, 11'h012, 3'b000);
      drive(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);

      for (int n = 0; n < 80; n++) begin
         a = {($urandom_range(0, 9) == 0) ? 16'h0000 : 16'h8000, 8'h01, 2'b00,
              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         drive($urandom_range(0, 1) == 1, {a[31:8], 2'b00, 4'($urandom_range(0, 15)), 2'b00},
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
               a, $urandom, 11'($urandom_range(0, 2047)),
               ($urandom_range(0, 7) == 0) ? 3'b100 : 3'b000);
      end
      idle();
      idle();

      // Reset asserted while responses are outstanding.
      drive(1'b1, 32'h8000_0100, 1'b1, 4'h0, 32'h8000_0104, 32'h0, 11'h3FF, 3'b000);
      @(posedge clk_i);
      #1;
      check("pre_rst_valid", {31'h0, mem_i_valid_o}, 32'h1);
      check("pre_rst_ack", {31'h0, mem_d_ack_o}, 32'h1);
      rst_i = 1'b0;
      #1;
      i_q.delete();
      d_q.delete();
      check("mid_rst_valid", {31'h0, mem_i_valid_o}, 32'h0);
      check("mid_rst_ack", {31'h0, mem_d_ack_o}, 32'h0);
      check("mid_rst_inst", mem_i_inst_o, 32'h0);
      check("mid_rst_data", mem_d_data_rd_o, 32'h0);
      check("mid_rst_tag", {21'h0, mem_d_resp_tag_o}, 32'h0);
      apply(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      apply(1'b1, 32'h8000_0200, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h155, 3'b000);
      idle();
      idle();
      check("i_q_drained", i_q.size(), 32'h0);
      check("d_q_drained", d_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
